// File: rtl/inst_q_pkg.sv
// Shared types and helpers for the multi-port instruction queue.
//   ds_state_t    : delay-slot retention state
//   fetch_entry_t : {pc, inst} payload at the default 32/32 widths
//   therm_count   : popcount of a thermometer-coded valid vector (up to 4 ports)
package inst_q_pkg;

  localparam int unsigned PC_W   = 32;
  localparam int unsigned INST_W = 32;

  typedef enum logic [1:0] {
    NORMAL  = 2'd0,
    DS_WAIT = 2'd1,
    DS_HOLD = 2'd2
  } ds_state_t;

  // Same field order as the storage word: pc in the upper bits, inst below.
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  // Number of set bits in a thermometer-coded vector, zero-extended to 4 bits.
  function automatic logic [2:0] therm_count(input logic [3:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < 4; i++) begin
      n = n + 3'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/inst_q_ram.sv
// Queue storage: DEPTH words of {pc, inst}, WR_W synchronous write ports and
// RD_W asynchronous read ports. Indices are already reduced modulo DEPTH.
//   clk      : write clock
//   wr_en    : per-port write enable
//   wr_idx   : per-port write index, PW bits each
//   wr_entry : per-port write word, {pc, inst}
//   rd_idx   : per-port read index, PW bits each
//   rd_entry : per-port read word, {pc, inst}
module inst_q_ram
  import inst_q_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WR_W  = 2,
  parameter int unsigned RD_W  = 2,
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 32
) (
  input  logic                              clk,
  input  logic [WR_W-1:0]                   wr_en,
  input  logic [WR_W*$clog2(DEPTH)-1:0]     wr_idx,
  input  logic [WR_W*(DW+AW)-1:0]           wr_entry,
  input  logic [RD_W*$clog2(DEPTH)-1:0]     rd_idx,
  output logic [RD_W*(DW+AW)-1:0]           rd_entry
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned EW = DW + AW;

  logic [EW-1:0] mem [DEPTH];

  // Write ports target distinct consecutive indices, so order does not matter.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(WR_W); i++) begin
      if (wr_en[i]) begin
        mem[wr_idx[i*PW +: PW]] <= wr_entry[i*EW +: EW];
      end
    end
  end

  // Zero-latency read ports.
  always_comb begin
    rd_entry = '0;
    for (int i = 0; i < int'(RD_W); i++) begin
      rd_entry[i*EW +: EW] = mem[rd_idx[i*PW +: PW]];
    end
  end

endmodule

// File: rtl/inst_queue_mp.sv
// Multi-port instruction queue between fetch and decode/issue, with
// delay-slot retention across a flush.
//   clk, rst          : clock, asynchronous active-low reset
//   flush, keep_ds    : empty the queue; optionally retain the delay slot
//   wr_valid/data/addr: up to WR_W fetched {pc, inst} pairs (thermometer valid)
//   full, overflow    : fewer than WR_W free entries; sticky dropped-write flag
//   rd_valid/data/addr: up to RD_W in-order entries from the head
//   rd_in_ds          : slot 0 is a retained delay-slot instruction
//   rd_pop            : number of slots consumed this cycle
//   count             : queue occupancy, 0..DEPTH
module inst_queue_mp
  import inst_q_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WR_W  = 2,
  parameter int unsigned RD_W  = 2,
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          keep_ds,
  input  logic [WR_W-1:0]               wr_valid,
  input  logic [WR_W*DW-1:0]            wr_data,
  input  logic [WR_W*AW-1:0]            wr_addr,
  output logic                          full,
  output logic                          overflow,
  output logic [RD_W-1:0]               rd_valid,
  output logic [RD_W*DW-1:0]            rd_data,
  output logic [RD_W*AW-1:0]            rd_addr,
  output logic                          rd_in_ds,
  input  logic [$clog2(RD_W+1)-1:0]     rd_pop,
  output logic [$clog2(DEPTH):0]        count
);

  localparam int unsigned PW      = $clog2(DEPTH);
  localparam int unsigned CW      = PW + 1;
  localparam int unsigned EW      = DW + AW;
  // At least two read ports so head+1 is always visible for delay-slot capture.
  localparam int unsigned NRP     = (RD_W < 2) ? 2 : RD_W;
  localparam int unsigned FULL_AT = DEPTH - WR_W;

  ds_state_t        state_q, state_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [EW-1:0]    hold_q, hold_d;

  logic [WR_W-1:0]      ram_we;
  logic [WR_W*PW-1:0]   wr_idx;
  logic [WR_W*EW-1:0]   wr_entry;
  logic [NRP*PW-1:0]    rd_idx;
  logic [NRP*EW-1:0]    rd_entry;

  logic [2:0]       nw;
  logic [2:0]       nw_acc;
  logic [CW-1:0]    pop_req;
  logic [CW-1:0]    np;
  logic             full_c;

  // Pack write ports and compute storage indices.
  always_comb begin
    wr_idx   = '0;
    wr_entry = '0;
    for (int i = 0; i < int'(WR_W); i++) begin
      wr_idx[i*PW +: PW]   = wr_ptr_q + PW'(i);
      wr_entry[i*EW +: EW] = {wr_addr[i*AW +: AW], wr_data[i*DW +: DW]};
    end
    rd_idx = '0;
    for (int i = 0; i < int'(NRP); i++) begin
      rd_idx[i*PW +: PW] = rd_ptr_q + PW'(i);
    end
  end

  inst_q_ram #(
    .DEPTH (DEPTH),
    .WR_W  (WR_W),
    .RD_W  (NRP),
    .DW    (DW),
    .AW    (AW)
  ) u_ram (
    .clk      (clk),
    .wr_en    (ram_we),
    .wr_idx   (wr_idx),
    .wr_entry (wr_entry),
    .rd_idx   (rd_idx),
    .rd_entry (rd_entry)
  );

  assign nw      = therm_count(4'(wr_valid));
  assign full_c  = (count_q > CW'(FULL_AT));
  assign pop_req = CW'(rd_pop);
  assign np      = (pop_req > count_q) ? count_q : pop_req;

  // Next-state and pointer/count update; flush outranks pop and write.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    hold_d     = hold_q;
    ram_we     = '0;
    nw_acc     = '0;

    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
      state_d  = NORMAL;
      if (keep_ds && (state_q == NORMAL)) begin
        if (count_q >= CW'(2)) begin
          hold_d  = rd_entry[EW +: EW];
          state_d = DS_HOLD;
        end else if ((count_q == CW'(1)) && wr_valid[0]) begin
          hold_d  = wr_entry[0 +: EW];
          state_d = DS_HOLD;
        end else begin
          state_d = DS_WAIT;
        end
      end
    end else begin
      case (state_q)
        DS_WAIT: begin
          // Only the first arriving instruction is the delay slot.
          if (wr_valid[0]) begin
            hold_d  = wr_entry[0 +: EW];
            state_d = DS_HOLD;
          end
        end
        default: begin
          if (wr_valid[0]) begin
            if (full_c) begin
              overflow_d = 1'b1;
            end else begin
              ram_we   = wr_valid;
              nw_acc   = nw;
              wr_ptr_d = wr_ptr_q + PW'(nw);
            end
          end
          if (state_q == DS_HOLD) begin
            // A pop here consumes only the held entry.
            if (rd_pop != '0) begin
              state_d = NORMAL;
            end
            count_d = count_q + CW'(nw_acc);
          end else begin
            rd_ptr_d = rd_ptr_q + PW'(np);
            count_d  = count_q + CW'(nw_acc) - np;
          end
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= NORMAL;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      hold_q     <= hold_d;
    end
  end

  // Read slots: storage in NORMAL, held delay slot alone in DS_HOLD, nothing in DS_WAIT.
  always_comb begin
    rd_valid = '0;
    rd_data  = '0;
    rd_addr  = '0;
    for (int i = 0; i < int'(RD_W); i++) begin
      rd_data[i*DW +: DW] = rd_entry[i*EW +: DW];
      rd_addr[i*AW +: AW] = rd_entry[i*EW + DW +: AW];
    end
    case (state_q)
      NORMAL: begin
        for (int i = 0; i < int'(RD_W); i++) begin
          rd_valid[i] = (CW'(i) < count_q);
        end
      end
      DS_HOLD: begin
        rd_valid[0]     = 1'b1;
        rd_data[0 +: DW] = hold_q[DW-1:0];
        rd_addr[0 +: AW] = hold_q[EW-1:DW];
      end
      default: begin
      end
    endcase
  end

  assign rd_in_ds = (state_q == DS_HOLD);
  assign full     = full_c;
  assign overflow = overflow_q;
  assign count    = count_q;

endmodule

// File: tb/tb_inst_queue_mp.sv
module tb_inst_queue_mp;
  import inst_q_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned WR_W  = 2;
  localparam int unsigned RD_W  = 2;
  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 32;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       flush;
  logic                       keep_ds;
  logic [WR_W-1:0]            wr_valid;
  logic [WR_W*DW-1:0]         wr_data;
  logic [WR_W*AW-1:0]         wr_addr;
  logic                       full;
  logic                       overflow;
  logic [RD_W-1:0]            rd_valid;
  logic [RD_W*DW-1:0]         rd_data;
  logic [RD_W*AW-1:0]         rd_addr;
  logic                       rd_in_ds;
  logic [$clog2(RD_W+1)-1:0]  rd_pop;
  logic [$clog2(DEPTH):0]     count;

  int checks   = 0;
  int failures = 0;

  inst_queue_mp #(
    .DEPTH (DEPTH), .WR_W (WR_W), .RD_W (RD_W), .DW (DW), .AW (AW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .keep_ds  (keep_ds),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_addr  (wr_addr),
    .full     (full),
    .overflow (overflow),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_addr  (rd_addr),
    .rd_in_ds (rd_in_ds),
    .rd_pop   (rd_pop),
    .count    (count)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] inst_of(input logic [AW-1:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  function automatic fetch_entry_t ent(input logic [AW-1:0] pc);
    fetch_entry_t e;
    e.pc   = pc;
    e.inst = inst_of(pc);
    return e;
  endfunction

  task automatic set_wr(input int n, input logic [AW-1:0] pc0, input logic [AW-1:0] pc1);
    wr_valid = '0;
    wr_data  = '0;
    wr_addr  = '0;
    if (n >= 1) begin
      wr_valid[0] = 1'b1;
      wr_addr[0 +: AW] = pc0;
      wr_data[0 +: DW] = inst_of(pc0);
    end
    if (n >= 2) begin
      wr_valid[1] = 1'b1;
      wr_addr[AW +: AW] = pc1;
      wr_data[DW +: DW] = inst_of(pc1);
    end
  endtask

  task automatic idle();
    flush   = 1'b0;
    keep_ds = 1'b0;
    rd_pop  = '0;
    set_wr(0, '0, '0);
  endtask

  // Apply current inputs at the next edge, then sample 1ns later with idle inputs.
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0;
    #12;
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (rd_valid !== 2'b00) begin failures++; $display("FAIL reset_rd_valid got=%b exp=00", rd_valid); end
    checks++; if (full !== 1'b0 || overflow !== 1'b0 || rd_in_ds !== 1'b0) begin
      failures++; $display("FAIL reset_flags got full=%b ovf=%b ds=%b exp 0/0/0", full, overflow, rd_in_ds);
    end
    rst = 1'b1;
  endtask

  task automatic test_fill_overflow();
    fetch_entry_t got;
    for (int k = 0; k < 8; k++) begin
      set_wr(2, 32'h1000 + 32'(8*k), 32'h1004 + 32'(8*k));
      tick();
    end
    checks++; if (count !== 5'd16) begin failures++; $display("FAIL fill_count got=%0d exp=16", count); end
    checks++; if (full !== 1'b1 || overflow !== 1'b0) begin
      failures++; $display("FAIL fill_flags got full=%b ovf=%b exp 1/0", full, overflow);
    end
    got = {rd_addr[AW-1:0], rd_data[DW-1:0]};
    checks++; if (got !== ent(32'h1000)) begin failures++; $display("FAIL fill_head got=%h exp=%h", got, ent(32'h1000)); end
    set_wr(2, 32'h2000, 32'h2004);
    tick();
    checks++; if (count !== 5'd16 || overflow !== 1'b1) begin
      failures++; $display("FAIL overflow got count=%0d ovf=%b exp 16/1", count, overflow);
    end
    // Pop and write at full: write is dropped because full is pre-update.
    set_wr(2, 32'h3000, 32'h3004);
    rd_pop = 2'd2;
    tick();
    checks++; if (count !== 5'd14 || full !== 1'b0) begin
      failures++; $display("FAIL pop_at_full got count=%0d full=%b exp 14/0", count, full);
    end
    checks++; if (rd_addr[AW-1:0] !== 32'h1008 || rd_addr[2*AW-1:AW] !== 32'h100C) begin
      failures++; $display("FAIL pop_at_full_head got=%h/%h exp=1008/100c", rd_addr[AW-1:0], rd_addr[2*AW-1:AW]);
    end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL overflow_sticky got=%b exp=1", overflow); end
    apply_reset();
    checks++; if (overflow !== 1'b0 || count !== 5'd0) begin
      failures++; $display("FAIL overflow_clear got ovf=%b count=%0d exp 0/0", overflow, count);
    end
  endtask

  task automatic test_pop();
    fetch_entry_t got;
    set_wr(2, 32'h100, 32'h104);
    tick();
    set_wr(1, 32'h108, 32'h0);
    tick();
    checks++; if (count !== 5'd3 || rd_valid !== 2'b11) begin
      failures++; $display("FAIL pop_setup got count=%0d vld=%b exp 3/11", count, rd_valid);
    end
    rd_pop = 2'd2;
    tick();
    got = {rd_addr[AW-1:0], rd_data[DW-1:0]};
    checks++; if (rd_valid !== 2'b01 || count !== 5'd1) begin
      failures++; $display("FAIL pop2 got vld=%b count=%0d exp 01/1", rd_valid, count);
    end
    checks++; if (got !== ent(32'h108)) begin failures++; $display("FAIL pop2_head got=%h exp=%h", got, ent(32'h108)); end
    rd_pop = 2'd2;
    tick();
    checks++; if (count !== 5'd0 || rd_valid !== 2'b00) begin
      failures++; $display("FAIL pop_clamp got count=%0d vld=%b exp 0/00", count, rd_valid);
    end
  endtask

  task automatic test_wrap();
    int errs;
    errs = 0;
    set_wr(1, 32'h300, 32'h0);
    tick();
    for (int k = 1; k <= 15; k++) begin
      set_wr(1, 32'h300 + 32'(4*k), 32'h0);
      rd_pop = 2'd1;
      tick();
      checks++;
      if (count !== 5'd1 || rd_addr[AW-1:0] !== 32'h300 + 32'(4*k)) begin
        failures++;
        $display("FAIL wrap_%0d got count=%0d pc=%h exp 1/%h", k, count, rd_addr[AW-1:0], 32'h300 + 32'(4*k));
      end
    end
    rd_pop = 2'd1;
    tick();
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL wrap_drain got=%0d exp=0", count); end
  endtask

  task automatic test_ds_hold();
    fetch_entry_t got;
    apply_reset();
    set_wr(2, 32'h200, 32'h204);
    tick();
    flush = 1'b1; keep_ds = 1'b1;
    tick();
    got = {rd_addr[AW-1:0], rd_data[DW-1:0]};
    checks++; if (rd_in_ds !== 1'b1 || rd_valid !== 2'b01 || count !== 5'd0) begin
      failures++; $display("FAIL ds_hold got ds=%b vld=%b count=%0d exp 1/01/0", rd_in_ds, rd_valid, count);
    end
    checks++; if (got !== ent(32'h204)) begin failures++; $display("FAIL ds_hold_entry got=%h exp=%h", got, ent(32'h204)); end
    set_wr(1, 32'h400, 32'h0);
    tick();
    checks++; if (rd_addr[AW-1:0] !== 32'h204 || count !== 5'd1 || rd_valid !== 2'b01) begin
      failures++; $display("FAIL ds_hold_write got pc=%h count=%0d vld=%b exp 204/1/01", rd_addr[AW-1:0], count, rd_valid);
    end
    rd_pop = 2'd1;
    tick();
    got = {rd_addr[AW-1:0], rd_data[DW-1:0]};
    checks++; if (rd_in_ds !== 1'b0 || got !== ent(32'h400) || count !== 5'd1) begin
      failures++; $display("FAIL ds_release got ds=%b ent=%h count=%0d exp 0/%h/1", rd_in_ds, got, count, ent(32'h400));
    end
    rd_pop = 2'd1;
    tick();
  endtask

  task automatic test_ds_wait();
    set_wr(1, 32'h200, 32'h0);
    tick();
    flush = 1'b1; keep_ds = 1'b1;
    tick();
    checks++; if (rd_valid !== 2'b00 || rd_in_ds !== 1'b0 || count !== 5'd0) begin
      failures++; $display("FAIL ds_wait got vld=%b ds=%b count=%0d exp 00/0/0", rd_valid, rd_in_ds, count);
    end
    tick();
    checks++; if (rd_valid !== 2'b00) begin failures++; $display("FAIL ds_wait_idle got vld=%b exp=00", rd_valid); end
    set_wr(2, 32'h204, 32'h208);
    tick();
    checks++; if (rd_valid !== 2'b01 || rd_in_ds !== 1'b1 || rd_addr[AW-1:0] !== 32'h204 || count !== 5'd0) begin
      failures++; $display("FAIL ds_wait_capture got vld=%b ds=%b pc=%h count=%0d exp 01/1/204/0", rd_valid, rd_in_ds, rd_addr[AW-1:0], count);
    end
    rd_pop = 2'd1;
    tick();
    checks++; if (rd_valid !== 2'b00 || rd_in_ds !== 1'b0 || count !== 5'd0) begin
      failures++; $display("FAIL ds_wait_discard got vld=%b ds=%b count=%0d exp 00/0/0", rd_valid, rd_in_ds, count);
    end
  endtask

  task automatic test_flush();
    // count==1 with port 0 writing in the flush cycle: port 0 becomes the delay slot.
    set_wr(1, 32'h500, 32'h0);
    tick();
    set_wr(2, 32'h504, 32'h508);
    flush = 1'b1; keep_ds = 1'b1;
    tick();
    checks++; if (rd_in_ds !== 1'b1 || rd_addr[AW-1:0] !== 32'h504 || count !== 5'd0) begin
      failures++; $display("FAIL ds_count1_write got ds=%b pc=%h count=%0d exp 1/504/0", rd_in_ds, rd_addr[AW-1:0], count);
    end
    // keep_ds in DS_HOLD acts as a plain flush.
    flush = 1'b1; keep_ds = 1'b1;
    tick();
    checks++; if (rd_in_ds !== 1'b0 || rd_valid !== 2'b00 || count !== 5'd0) begin
      failures++; $display("FAIL flush_in_hold got ds=%b vld=%b count=%0d exp 0/00/0", rd_in_ds, rd_valid, count);
    end
    set_wr(2, 32'h600, 32'h604);
    tick();
    set_wr(2, 32'h608, 32'h60C);
    flush = 1'b1;
    tick();
    checks++; if (count !== 5'd0 || rd_valid !== 2'b00 || rd_in_ds !== 1'b0) begin
      failures++; $display("FAIL flush_plain got count=%0d vld=%b ds=%b exp 0/00/0", count, rd_valid, rd_in_ds);
    end
  endtask

  task automatic test_async_reset();
    set_wr(2, 32'h200, 32'h204);
    tick();
    flush = 1'b1; keep_ds = 1'b1;
    tick();
    set_wr(1, 32'h400, 32'h0);
    tick();
    checks++; if (rd_in_ds !== 1'b1 || count !== 5'd1) begin
      failures++; $display("FAIL async_setup got ds=%b count=%0d exp 1/1", rd_in_ds, count);
    end
    rst = 1'b0;
    #1;
    checks++; if (rd_valid !== 2'b00 || rd_in_ds !== 1'b0 || count !== 5'd0) begin
      failures++; $display("FAIL async_reset got vld=%b ds=%b count=%0d exp 00/0/0", rd_valid, rd_in_ds, count);
    end
    #1;
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fill_overflow();
    test_pop();
    test_wrap();
    test_ds_hold();
    test_ds_wait();
    test_flush();
    test_async_reset();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
